// File: rtl/mux_arb_pkg.sv
// Shared types, select encodings and the rotate-priority search used by the
// round-robin mux arbiter.
package mux_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } arb_state_t;

  localparam int unsigned SEL_W = 2;

  localparam logic [SEL_W-1:0] S0 = 2'b00;
  localparam logic [SEL_W-1:0] S1 = 2'b01;
  localparam logic [SEL_W-1:0] S2 = 2'b10;
  localparam logic [SEL_W-1:0] S3 = 2'b11;

  // First set bit of req searching upward from ptr+1 with wrap. Walking from the
  // farthest slot to the nearest lets the nearest set bit overwrite the result.
  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] ptr,
                                                input logic [3:0]       req);
    logic [SEL_W-1:0] idx;
    next_idx = ptr;
    for (int i = 4; i >= 1; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) next_idx = idx;
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority encoder: picks the next requester after ptr.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [3:0]       req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [SEL_W-1:0] win_o,
  output logic             any_o
);

  always_comb begin
    win_o = next_idx(ptr_i, req_i);
    any_o = |req_i;
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter feeding a single registered output slot with valid/ready
// backpressure; grants are combinational so requesters see them at the capture edge.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned DW   = 4,
  parameter int unsigned NREQ = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [DW-1:0]     in0,
  input  logic [DW-1:0]     in1,
  input  logic [DW-1:0]     in2,
  input  logic [DW-1:0]     in3,
  input  logic              out_ready,
  output logic [NREQ-1:0]   gnt,
  output logic [SEL_W-1:0]  sel,
  output logic [DW-1:0]     out,
  output logic              out_valid
);

  arb_state_t       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [DW-1:0]    out_q, out_d;

  logic [SEL_W-1:0] win;
  logic             any;
  logic             slot_free;
  logic [DW-1:0]    win_data;

  rr_pick u_rr_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .win_o (win),
    .any_o (any)
  );

  always_comb begin
    win_data = in0;
    unique case (win)
      S0: win_data = in0;
      S1: win_data = in1;
      S2: win_data = in2;
      S3: win_data = in3;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    out_d     = out_q;
    gnt       = '0;
    slot_free = (state_q == IDLE) || out_ready;
    if (slot_free) begin
      if (any) begin
        state_d  = FULL;
        ptr_d    = win;
        sel_d    = win;
        out_d    = win_data;
        // No grant may escape while the async reset is holding the slot empty.
        gnt[win] = reset;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= S3;
      sel_q   <= S0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign sel       = sel_q;
  assign out       = out_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: inputs change 1 time unit after posedge,
// outputs are sampled on negedge.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] in0, in1, in2, in3;
  logic       out_ready;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic [3:0] out;
  logic       out_valid;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(
    .DW   (4),
    .NREQ (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .out_ready (out_ready),
    .gnt       (gnt),
    .sel       (sel),
    .out       (out),
    .out_valid (out_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  // Running properties: one-hot grant, grant only to a requester, grant leads to
  // valid data, and a stalled slot holds its contents.
  logic       prev_g     = 1'b0;
  logic       prev_stall = 1'b0;
  logic [3:0] prev_out   = '0;
  logic [1:0] prev_sel   = '0;

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      prev_g     = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check("onehot0", 32'($onehot0(gnt)), 1);
      check("gnt_req", 32'(gnt & ~req), 0);
      if (prev_g) check("gnt_then_valid", 32'(out_valid), 1);
      if (prev_stall) begin
        check("stall_out", 32'(out), 32'(prev_out));
        check("stall_sel", 32'(sel), 32'(prev_sel));
      end
      prev_g     = |gnt;
      prev_stall = out_valid && !out_ready;
      prev_out   = out;
      prev_sel   = sel;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; req = 4'b1111; out_ready = 1'b0;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;

    // Reset values; grant suppressed while in reset even with requests pending
    @(negedge clk);
    check("rst_out",   32'(out), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_sel",   32'(sel), 0);
    check("rst_gnt",   32'(gnt), 0);

    // Fairness with all four requesting
    drive_edge();
    reset = 1'b1; in0 = 4'd1; in1 = 4'd2; in2 = 4'd3; in3 = 4'd4; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rr_gnt", 32'(gnt), 1 << (k % 4));
      if (k > 0) begin
        check("rr_out",   32'(out), (k - 1) % 4 + 1);
        check("rr_sel",   32'(sel), (k - 1) % 4);
        check("rr_valid", 32'(out_valid), 1);
      end
    end

    // Asynchronous reset while holding data
    #2 reset = 1'b0; in0 = 4'hA;
    #1;
    check("arst_out",   32'(out), 0);
    check("arst_valid", 32'(out_valid), 0);
    check("arst_sel",   32'(sel), 0);
    check("arst_gnt",   32'(gnt), 0);
    drive_edge();
    reset = 1'b1;
    @(negedge clk);
    check("first_gnt",   32'(gnt), 'b0001);
    check("first_valid", 32'(out_valid), 0);

    // Backpressure: A captured from in0, then stalled for 5 cycles
    drive_edge();
    out_ready = 1'b0; req = 4'b0110;
    repeat (5) begin
      @(negedge clk);
      check("bp_out",   32'(out), 'hA);
      check("bp_sel",   32'(sel), 0);
      check("bp_gnt",   32'(gnt), 0);
      check("bp_valid", 32'(out_valid), 1);
    end
    drive_edge();
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_rel_gnt0", 32'(gnt), 'b0010);
    @(negedge clk);
    check("bp_rel_gnt1", 32'(gnt), 'b0100);
    check("bp_rel_out1", 32'(out), 2);
    check("bp_rel_sel1", 32'(sel), 1);
    @(negedge clk);
    check("bp_rel_gnt2", 32'(gnt), 'b0010);
    check("bp_rel_out2", 32'(out), 3);
    check("bp_rel_sel2", 32'(sel), 2);

    // Sparse: only requester 2
    drive_edge();
    req = 4'b0100; in2 = 4'h7;
    @(negedge clk);
    check("sp_gnt0", 32'(gnt), 'b0100);
    repeat (2) begin
      @(negedge clk);
      check("sp_gnt",   32'(gnt), 'b0100);
      check("sp_out",   32'(out), 7);
      check("sp_sel",   32'(sel), 2);
      check("sp_valid", 32'(out_valid), 1);
    end
    drive_edge();
    req = 4'b0000;
    @(negedge clk);
    check("sp_last_gnt",   32'(gnt), 0);
    check("sp_last_out",   32'(out), 7);
    check("sp_last_valid", 32'(out_valid), 1);
    @(negedge clk);
    check("sp_drop_valid", 32'(out_valid), 0);
    check("sp_drop_out",   32'(out), 7);
    check("sp_drop_sel",   32'(sel), 2);

    // Skip/wrap from ptr=2, then req[3] pulses only while stalled
    drive_edge();
    req = 4'b0011; in0 = 4'h5; in1 = 4'h6;
    @(negedge clk);
    check("wr_gnt0", 32'(gnt), 'b0001);
    @(negedge clk);
    check("wr_gnt1", 32'(gnt), 'b0010);
    check("wr_out0", 32'(out), 5);
    check("wr_sel0", 32'(sel), 0);
    drive_edge();
    out_ready = 1'b0; req = 4'b1000;
    @(negedge clk);
    check("sk_gnt_a", 32'(gnt), 0);
    check("sk_out",   32'(out), 6);
    check("sk_sel",   32'(sel), 1);
    drive_edge();
    req = 4'b0000;
    @(negedge clk);
    check("sk_gnt_b", 32'(gnt), 0);
    drive_edge();
    out_ready = 1'b1; req = 4'b0001;
    @(negedge clk);
    check("sk_gnt_c", 32'(gnt), 'b0001);
    check("sk_out_c", 32'(out), 6);
    @(negedge clk);
    check("sk_gnt_d", 32'(gnt), 'b0001);
    check("sk_out_d", 32'(out), 5);
    check("sk_sel_d", 32'(sel), 0);
    drive_edge();
    req = 4'b0000;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
